// File: rtl/instr_encoder_if.sv
`timescale 1ns/1ps
// Request fields plus the instruction-memory write port and status of instr_encoder.
// The requester holds req_valid until req_ready; the encoder drives mem_* and status.
interface instr_encoder_if #(
  parameter int AW = 6
);
  logic           clear;
  logic           req_valid;
  logic           req_ready;
  logic [2:0]     cls;
  logic [3:0]     cond;
  logic [3:0]     cmd;
  logic           s_bit;
  logic           i_bit;
  logic           l_bit;
  logic [3:0]     rn;
  logic [3:0]     rd;
  logic [3:0]     rm;
  logic [23:0]    imm;
  logic           mem_we;
  logic [AW-1:0]  mem_addr;
  logic [31:0]    mem_wdata;
  logic           err;
  logic           full;
  logic [AW:0]    count;

  modport master (
    output clear, req_valid, cls, cond, cmd, s_bit, i_bit, l_bit, rn, rd, rm, imm,
    input  req_ready, mem_we, mem_addr, mem_wdata, err, full, count
  );

  modport slave (
    input  clear, req_valid, cls, cond, cmd, s_bit, i_bit, l_bit, rn, rd, rm, imm,
    output req_ready, mem_we, mem_addr, mem_wdata, err, full, count
  );
endinterface

// File: rtl/instr_encoder.sv
`timescale 1ns/1ps
// Packs field-level requests into 32-bit instructions and writes them sequentially to memory.
// Accept edge N -> mem_we in cycle N+2, one request per 3 cycles; req_ready drops while busy or full.
module instr_encoder #(
  parameter int AW    = 6,
  parameter int DEPTH = 64,
  parameter int BASE  = 0
) (
  input logic            clk,
  input logic            reset,
  instr_encoder_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ENCODE, S_WRITE, S_ERR} state_e;

  typedef struct packed {
    logic [2:0]  cls;
    logic [3:0]  cond;
    logic [3:0]  cmd;
    logic        s_bit;
    logic        i_bit;
    logic        l_bit;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [23:0] imm;
  } req_t;

  localparam logic [AW-1:0] BASE_A  = AW'(BASE);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

  state_e        state_q, state_d;
  logic          started_q;
  req_t          req_q, req_d;
  logic [31:0]   word_q, word_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   count_q, count_d;
  logic          clr_pend_q, clr_pend_d;

  req_t          req_in;
  logic [31:0]   enc_word;
  logic          enc_legal;
  logic          full;
  logic          accept;
  logic          clr_now;

  assign req_in = '{cls: bus.cls, cond: bus.cond, cmd: bus.cmd, s_bit: bus.s_bit,
                    i_bit: bus.i_bit, l_bit: bus.l_bit, rn: bus.rn, rd: bus.rd,
                    rm: bus.rm, imm: bus.imm};

  assign full    = (count_q == DEPTH_C);
  assign accept  = bus.req_valid & bus.req_ready;
  assign clr_now = bus.clear | clr_pend_q;

  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b0;
    case (req_q.cls)
      3'd0: begin
        enc_legal = (req_q.cmd == 4'b0100) || (req_q.cmd == 4'b0010) ||
                    (req_q.cmd == 4'b0000) || (req_q.cmd == 4'b1100);
        enc_word  = {req_q.cond, 2'b00, req_q.i_bit, req_q.cmd, req_q.s_bit, req_q.rn, req_q.rd,
                     req_q.i_bit ? req_q.imm[11:0] : {8'b0, req_q.rm}};
      end
      3'd1: begin
        enc_legal = 1'b1;
        enc_word  = {req_q.cond, 2'b01, 5'b01100, req_q.l_bit, req_q.rn, req_q.rd, req_q.imm[11:0]};
      end
      3'd2: begin
        enc_legal = 1'b1;
        enc_word  = {req_q.cond, 2'b10, 2'b10, req_q.imm};
      end
      3'd3: begin
        enc_legal = (req_q.cmd[2:0] == 3'b000) || (req_q.cmd[2:0] == 3'b100) ||
                    (req_q.cmd[2:0] == 3'b110);
        // MUL swaps rd/rn relative to DP and repeats rn in the low nibble.
        enc_word  = {req_q.cond, 2'b00, 2'b00, req_q.cmd[2:0], req_q.s_bit, req_q.rd, req_q.rn,
                     req_q.rm, 4'b1001, req_q.rn};
      end
      3'd4: begin
        enc_legal = 1'b1;
        enc_word  = {req_q.cond, 2'b11, 3'b000, req_q.cmd[1:0], req_q.s_bit, req_q.rn, req_q.rd,
                     8'b0, req_q.rm};
      end
      default: begin
        enc_legal = 1'b0;
        enc_word  = '0;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    word_d     = word_q;
    addr_d     = addr_q;
    count_d    = count_q;
    clr_pend_d = clr_pend_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          req_d   = req_in;
          state_d = S_ENCODE;
        end
        if (clr_now) begin
          addr_d     = BASE_A;
          count_d    = '0;
          clr_pend_d = 1'b0;
        end
      end
      S_ENCODE: begin
        // A clear seen here waits until the in-flight word has been written.
        clr_pend_d = clr_pend_q | bus.clear;
        if (enc_legal) begin
          word_d  = enc_word;
          state_d = S_WRITE;
        end else begin
          state_d = S_ERR;
        end
      end
      S_WRITE: begin
        state_d    = S_IDLE;
        clr_pend_d = 1'b0;
        if (clr_now) begin
          addr_d  = BASE_A;
          count_d = '0;
        end else begin
          addr_d  = addr_q + 1'b1;
          count_d = count_q + 1'b1;
        end
      end
      S_ERR: begin
        state_d    = S_IDLE;
        clr_pend_d = 1'b0;
        if (clr_now) begin
          addr_d  = BASE_A;
          count_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      started_q  <= 1'b0;
      req_q      <= '0;
      word_q     <= '0;
      addr_q     <= BASE_A;
      count_q    <= '0;
      clr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      started_q  <= 1'b1;
      req_q      <= req_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      clr_pend_q <= clr_pend_d;
    end
  end

  assign bus.req_ready = started_q & (state_q == S_IDLE) & ~full;
  assign bus.mem_we    = (state_q == S_WRITE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = word_q;
  assign bus.err       = (state_q == S_ERR);
  assign bus.full      = full;
  assign bus.count     = count_q;
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Instruction encoder and loader, the write-side counterpart of the processor's instruction decoder. It accepts field-level instruction requests over a valid/ready handshake and packs each into a 32-bit word: {cond, op, funct, rn, rd, src2}, plus the MUL and FPU sub-formats. It then writes the words sequentially into instruction memory. Illegal field combinations are rejected with an error pulse and are never written, so memory only holds words the decoder can legally interpret.

Parameters:
AW, 6, instruction-memory word-address width
DEPTH, 64, number of writable words (must be <= 2**AW)
BASE, 0, first word address written after reset or clear

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
clear  in  1  synchronous pulse: return to BASE, drop full, count=0
req_valid  in  1  request present
req_ready  out  1  encoder can accept a request this cycle
cls  in  3  class: 0 DP, 1 MEM, 2 BR, 3 MUL, 4 FPU, 5-7 illegal
cond  in  4  condition field, bits [31:28]
cmd  in  4  DP: ALU cmd; MUL: cmd[2:0]; FPU: cmd[1:0]
s_bit  in  1  set-flags (DP, MUL, FPU)
i_bit  in  1  DP immediate select
l_bit  in  1  MEM load(1)/store(0)
rn  in  4  first source register
rd  in  4  destination register
rm  in  4  second register (DP reg form, MUL multiplier)
imm  in  24  immediate: DP uses [11:0], MEM [11:0], BR [23:0]
mem_we  out  1  instruction-memory write strobe
mem_addr  out  AW  write word address
mem_wdata  out  32  encoded instruction
err  out  1  one-cycle pulse: last accepted request was illegal
full  out  1  DEPTH words written
count  out  AW+1  words written since reset/clear

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; req_ready=0 for the first edge, then 1; mem_we=0; mem_addr=BASE; mem_wdata=0; err=0; full=0; count=0.
- States:
  - IDLE: req_ready = ~full. On req_valid&req_ready, latch all fields and go to ENCODE.
  - ENCODE: req_ready=0. Compute the word and legality, then go to WRITE if legal, else ERR.
  - WRITE: mem_we=1 for exactly one cycle with mem_addr and mem_wdata; count+1; go to IDLE.
  - ERR: err=1 for one cycle; no write; go to IDLE.
  - Latency: accept edge N, mem_we high in cycle N+2. Throughput is 1 request per 3 cycles.
- Encoding (bits [31:28]=cond always):
  - DP: op=00, funct={i_bit, cmd, s_bit}, [19:16]=rn, [15:12]=rd. src2 = imm[11:0] if i_bit, else {8'b0, rm}. Legal cmd: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR.
  - MEM: op=01, funct={1'b0, 1'b1, 1'b1, 1'b0, 1'b0, l_bit}, rn, rd, src2=imm[11:0].
  - BR: op=10, [25:24]=2'b10, [23:0]=imm.
  - MUL: op=00, funct={2'b00, cmd[2:0], s_bit}. [19:16]=rd, [15:12]=rn, [11:8]=rm, [7:4]=1001, [3:0]=rn. Legal cmd[2:0]: 000, 100, 110.
  - FPU: op=11, funct={1'b0, 2'b00, cmd[1:0], s_bit}, rn, rd, src2={8'b0, rm}.
  - Illegal: cls 5-7, or a cmd outside its class's legal set.
- Address/full:
  - After each write, mem_addr increments by 1, wrapping modulo 2**AW.
  - When count reaches DEPTH, full=1 and req_ready=0 until clear or reset.
  - An illegal request does not consume an address.
- clear:
  - In IDLE or ERR it takes effect at the next edge.
  - In ENCODE or WRITE it takes effect after that word's write completes; the in-flight write is not lost.
- reset low mid-operation aborts immediately. mem_we drops asynchronously and no partial write occurs.
- req_valid while req_ready=0 is ignored; requesters must hold req_valid until the handshake completes.

Test Plan:
- DP ADD, cond=E, i_bit=1, s_bit=1, rn=1, rd=2, imm=0x005 -> mem_wdata=0xE2912005 at BASE, mem_we high 2 cycles after accept, count=1.
- MUL cmd=000, s_bit=0, cond=E, rd=3, rn=1, rm=2 -> mem_wdata=0xE0031291 at the next address.
- BR cond=A, imm=0x000010 -> 0xAA000010. MEM load cond=E, rn=0, rd=4, imm=0x008 -> 0xE5904008.
- cls=6, then DP cmd=1111 -> err pulses twice, no mem_we, address and count unchanged.
- DEPTH=4: after four legal writes full=1 and req_ready=0 with req_valid held. clear -> next write at BASE, count=1.
- Assert reset low during WRITE -> mem_we=0 immediately, all outputs at reset values. After release, the first request writes to BASE.
